seven_seg_scanner: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display on the board.
- Scans NUM_DIGITS hex nibbles at a programmable refresh rate.
- Snapshots the input once per frame, so a digit never changes mid-frame (no tearing).
- Adds per-digit enable, decimal points, anti-ghosting blank guard and a frame_start strobe.
- Sits between user datapaths and the board's segments/dp/anodes pins.

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seven_seg_scanner_if.sv | 25 ++
 rtl/seven_seg_hex_to_seg7.sv | 11 +
 rtl/seven_seg_scanner.sv | 110 +++++++++++
 tb/tb_seven_seg_scanner.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and the active-low hex-to-segment table for the seven-segment scanner.
package seven_seg_pkg;

    typedef logic [6:0] seg7_t;  // {g,f,e,d,c,b,a}, active-low

    localparam seg7_t SEG_OFF = 7'h7F;
    localparam logic  DP_OFF  = 1'b1;

    localparam seg7_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Data-in / display-out bundle of the scanner; master is the user side, slave the scanner.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    import seven_seg_pkg::*;

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    seg7_t                   segments;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anodes;
    logic                    frame_start;

    modport master (
        output value, digit_en, dp_in,
        input  segments, dp, anodes, frame_start
    );

    modport slave (
        input  value, digit_en, dp_in,
        output segments, dp, anodes, frame_start
    );

endinterface

// File: rtl/seven_seg_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg7_t      o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode display driver with per-frame input snapshot.
// Optional leading-zero suppression when SEVEN_SEG_LZ_BLANK_EN is defined.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 0
) (
    input  logic                i_clock,
    input  logic                i_reset,   // active-low, asynchronous
    seven_seg_scanner_if.slave  bus
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRE_W-1:0]        r_pre;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_snap_val;
    logic [NUM_DIGITS-1:0]   r_snap_en;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic                    r_load_pending;
    logic [NUM_DIGITS-1:0]   r_anodes;
    seg7_t                   r_segments;
    logic                    r_dp;
    logic                    r_frame_start;

    logic       w_tick;
    logic       w_wrap;
    logic       w_load;
    logic       w_guard_ok;
    logic       w_lz_blank;
    logic       w_lit;
    logic [3:0] w_nib;
    seg7_t      w_seg;

    assign w_tick = (r_pre == PRE_W'(REFRESH_DIV - 1));
    assign w_wrap = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_load = (w_tick && w_wrap) || r_load_pending;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign w_guard_ok = 1'b1;
        end else begin : g_guard
            assign w_guard_ok = (r_pre >= PRE_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // w_hi_zero[i]: every snapshot nibble at index >= i is zero.
    logic [NUM_DIGITS-1:0] w_hi_zero;
    always_comb begin
        logic acc;
        acc       = 1'b1;
        w_hi_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (r_snap_val[4*i +: 4] == 4'h0);
            w_hi_zero[i] = acc;
        end
    end
    assign w_lz_blank = (r_idx != '0) && w_hi_zero[r_idx];
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_nib = r_snap_val[{r_idx, 2'b00} +: 4];
    assign w_lit = r_snap_en[r_idx] && w_guard_ok && !w_lz_blank;

    hex_to_seg7 u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pre          <= '0;
            r_idx          <= '0;
            r_snap_val     <= '0;
            r_snap_en      <= '0;
            r_snap_dp      <= '0;
            r_load_pending <= 1'b1;
            r_anodes       <= '1;
            r_segments     <= SEG_OFF;
            r_dp           <= DP_OFF;
            r_frame_start  <= 1'b0;
        end else begin
            r_pre          <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick)
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            r_load_pending <= 1'b0;
            // Snapshot only at the frame boundary so a digit never changes mid-frame.
            if (w_load) begin
                r_snap_val <= bus.value;
                r_snap_en  <= bus.digit_en;
                r_snap_dp  <= bus.dp_in;
            end
            r_frame_start  <= w_load;
            r_anodes       <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
            r_segments     <= w_lit ? w_seg : SEG_OFF;
            r_dp           <= w_lit ? ~r_snap_dp[r_idx] : DP_OFF;
        end
    end

    assign bus.anodes      = r_anodes;
    assign bus.segments    = r_segments;
    assign bus.dp          = r_dp;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner against a frame/slot arithmetic model.
module tb_seven_seg_scanner;
    import seven_seg_pkg::*;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] EXP_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_chk = 0;
    int n_err = 0;

    // Model: edge count since reset release determines slot/position arithmetically.
    int          n_edge;
    logic [15:0] m_val;
    logic [3:0]  m_en;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit lz_hidden(input int d);
`ifdef SEVEN_SEG_LZ_BLANK_EN
        return (d > 0) && ((m_val >> (4 * d)) == 16'h0);
`else
        return (d < 0);
`endif
    endfunction

    task automatic model_reset();
        n_edge = 0;
        m_val  = '0;
        m_en   = '0;
        m_dp   = '0;
        e_an   = 4'hF;
        e_seg  = 7'h7F;
        e_dp   = 1'b1;
        e_fs   = 1'b0;
    endtask

    task automatic model_edge();
        int pre;
        int idx;
        bit lit;
        n_edge++;
        pre   = (n_edge - 1) % RD;
        idx   = ((n_edge - 1) / RD) % ND;
        lit   = m_en[idx] && (pre >= BC) && !lz_hidden(idx);
        e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
        e_seg = lit ? EXP_SEG[m_val[4*idx +: 4]] : 7'h7F;
        e_dp  = lit ? ~m_dp[idx] : 1'b1;
        e_fs  = (n_edge == 1) || (n_edge % (RD * ND) == 0);
        if (e_fs) begin
            m_val = bus.value;
            m_en  = bus.digit_en;
            m_dp  = bus.dp_in;
        end
    endtask

    task automatic check_outputs();
        chk("anodes",      32'(bus.anodes),   32'(e_an));
        chk("segments",    32'(bus.segments), 32'(e_seg));
        chk("dp",          32'(bus.dp),       32'(e_dp));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
        chk("onecold",     32'($countones(~bus.anodes) <= 1), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_anodes"}, 32'(bus.anodes),      32'hF);
        chk({tag, "_seg"},    32'(bus.segments),    32'h7F);
        chk({tag, "_dp"},     32'(bus.dp),          32'h1);
        chk({tag, "_fs"},     32'(bus.frame_start), 32'h0);
    endtask

    task automatic drive_random();
        logic [31:0] v;
        v = $urandom;
        v = v >> (4 * $urandom_range(0, 4));
        bus.value    = v[15:0];
        bus.digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        bus.dp_in    = 4'($urandom);
    endtask

    task automatic run(input int cycles, input bit rnd);
        repeat (cycles) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
            if (rnd && $urandom_range(0, 5) == 0)
                drive_random();
        end
    endtask

    initial begin
        bus.value    = 16'h0;
        bus.digit_en = 4'h0;
        bus.dp_in    = 4'h0;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            check_reset("rst_hold");
        end

        bus.value    = 16'h1234;
        bus.digit_en = 4'hF;
        bus.dp_in    = 4'h0;
        rst_n        = 1'b1;
        run(64, 1'b0);

        run(6, 1'b0);
        bus.value = 16'hABCD;
        run(64, 1'b0);

        bus.digit_en = 4'b0101;
        bus.dp_in    = 4'b0001;
        run(64, 1'b0);

        bus.digit_en = 4'hF;
        bus.dp_in    = 4'h0;
        bus.value    = 16'h0007;
        run(48, 1'b0);
        bus.value = 16'h0000;
        run(48, 1'b0);
        bus.digit_en = 4'h0;
        bus.value    = 16'h8888;
        run(32, 1'b0);

        run(1500, 1'b1);

        // Asynchronous reset landing between clock edges, mid-slot.
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_reset("async_hold");
        end
        rst_n = 1'b1;
        run(300, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
